// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the unified-RAM byte sequencer.
package mem_ctrl_pkg;

  localparam int          DEFAULT_ADDR_W = 17;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  // Byte counts an access may carry; anything else is treated as a full word.
  localparam logic [2:0]  LEN_BYTE = 3'd1;
  localparam logic [2:0]  LEN_HALF = 3'd2;
  localparam logic [2:0]  LEN_WORD = 3'd4;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_RD   = 2'd1,
    MC_WR   = 2'd2,
    MC_DONE = 2'd3
  } mcState_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } mcOwner_e;

  // Collapse the requested length onto the three supported byte counts.
  function automatic logic [2:0] normLen(input logic [2:0] len);
    case (len)
      LEN_BYTE: return LEN_BYTE;
      LEN_HALF: return LEN_HALF;
      default:  return LEN_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_assemble.sv
// Byte counter plus little-endian word assembler for the RAM sequencer.
// Byte k of a read lands in bits [8k+7:8k]; the counter runs one ahead of
// the capture slot because the RAM returns data one cycle after the address.
module mem_ctrl_assemble
  import mem_ctrl_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        clear_i,
  input  logic        step_i,
  input  logic        capture_i,
  input  logic [7:0]  din_i,
  output logic [2:0]  cnt_o,
  output logic [31:0] wordNext_o
);

  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [1:0]  slot;

  // Next counter/word: clear on a new access, otherwise advance and drop the returning byte into its lane.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    slot   = cnt_q[1:0] - 2'd1;
    if (clear_i) begin
      cnt_d  = 3'd0;
      word_d = ZERO_WORD;
    end else begin
      if (step_i) begin
        cnt_d = cnt_q + 3'd1;
      end
      if (capture_i) begin
        word_d[{slot, 3'b000} +: 8] = din_i;
      end
    end
  end

  // Counter and assembly register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q  <= 3'd0;
      word_q <= ZERO_WORD;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign wordNext_o = word_d;

endmodule

// File: rtl/mem_ctrl.sv
// Single-port arbiter/sequencer for the byte-wide unified RAM.
// MEM-stage accesses win over IF fetches; each access is split into byte
// cycles and completes with a one-cycle registered done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [31:0]       if_addr_in,
  input  logic              flush_in,
  output logic [31:0]       if_data_out,
  output logic              if_done_out,
  output logic              if_blk_out,
  input  logic              mem_req_in,
  input  logic              mem_we_in,
  input  logic [2:0]        mem_len_in,
  input  logic [31:0]       mem_addr_in,
  input  logic [31:0]       mem_wdata_in,
  output logic [31:0]       mem_rdata_out,
  output logic              mem_done_out,
  output logic              mem_blk_out,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic              ram_wr_out,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  mcState_e    state_q, state_d;
  mcOwner_e    owner_q;
  logic [31:0] base_q, wdata_q;
  logic [2:0]  len_q;
  logic        ifDone_q, memDone_q;
  logic [31:0] ifData_q, memRdata_q;

  logic        acceptMem, acceptIf, asmStep, asmCapture, enterDone;
  logic [2:0]  cnt;
  logic [31:0] wordNext;
  logic [31:0] addrSum;

  assign addrSum   = base_q + {29'd0, cnt};
  assign enterDone = (state_q != MC_DONE) && (state_d == MC_DONE);

  mem_ctrl_assemble u_assemble (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .clear_i    (acceptMem | acceptIf),
    .step_i     (asmStep),
    .capture_i  (asmCapture),
    .din_i      (ram_din),
    .cnt_o      (cnt),
    .wordNext_o (wordNext)
  );

  // Sequencer: arbitration, byte stepping, flush abort and the RAM-side strobes.
  always_comb begin
    state_d      = state_q;
    acceptMem    = 1'b0;
    acceptIf     = 1'b0;
    asmStep      = 1'b0;
    asmCapture   = 1'b0;
    ram_addr_out = '0;
    ram_wr_out   = 1'b0;
    ram_dout     = 8'h00;
    case (state_q)
      MC_IDLE: begin
        if (mem_req_in) begin
          acceptMem = 1'b1;
          state_d   = mem_we_in ? MC_WR : MC_RD;
        end else if (if_req_in && !flush_in) begin
          acceptIf = 1'b1;
          state_d  = MC_RD;
        end
      end
      MC_RD: begin
        if (cnt < len_q) begin
          ram_addr_out = addrSum[ADDR_W-1:0];
        end
        asmCapture = (cnt != 3'd0);
        if (owner_q == OWN_IF && flush_in) begin
          state_d = MC_IDLE;
        end else if (cnt == len_q) begin
          state_d = MC_DONE;
        end else begin
          asmStep = 1'b1;
        end
      end
      MC_WR: begin
        ram_addr_out = addrSum[ADDR_W-1:0];
        ram_wr_out   = 1'b1;
        ram_dout     = wdata_q[{cnt[1:0], 3'b000} +: 8];
        if (cnt == len_q - 3'd1) begin
          state_d = MC_DONE;
        end else begin
          asmStep = 1'b1;
        end
      end
      MC_DONE: begin
        state_d = MC_IDLE;
      end
      default: begin
        state_d = MC_IDLE;
      end
    endcase
  end

  // State register and the access descriptor latched when a request is accepted.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= MC_IDLE;
      owner_q <= OWN_IF;
      base_q  <= ZERO_WORD;
      len_q   <= 3'd0;
      wdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (acceptMem) begin
        owner_q <= OWN_MEM;
        base_q  <= mem_addr_in;
        len_q   <= normLen(mem_len_in);
        wdata_q <= mem_wdata_in;
      end else if (acceptIf) begin
        owner_q <= OWN_IF;
        base_q  <= if_addr_in;
        len_q   <= LEN_WORD;
      end
    end
  end

  // Registered done pulses and result words, loaded on the edge that enters DONE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ifDone_q   <= 1'b0;
      memDone_q  <= 1'b0;
      ifData_q   <= ZERO_WORD;
      memRdata_q <= ZERO_WORD;
    end else begin
      ifDone_q  <= enterDone && (owner_q == OWN_IF);
      memDone_q <= enterDone && (owner_q == OWN_MEM);
      if (enterDone && owner_q == OWN_IF) begin
        ifData_q <= wordNext;
      end
      if (enterDone && owner_q == OWN_MEM && state_q == MC_RD) begin
        memRdata_q <= wordNext;
      end
    end
  end

  // A branch taken during the completion cycle still kills the fetch result.
  assign if_done_out   = ifDone_q & ~flush_in;
  assign mem_done_out  = memDone_q;
  assign if_data_out   = ifData_q;
  assign mem_rdata_out = memRdata_q;
  assign if_blk_out    = if_req_in & ~if_done_out;
  assign mem_blk_out   = mem_req_in & ~mem_done_out;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a byte-array RAM, a reference byte image
// updated from completed stores, and per-scenario tasks.
module tb_mem_ctrl;

   localparam int AW    = 17;
   localparam int MEMSZ = 1 << AW;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          if_req_in = 1'b0;
   logic [31:0]   if_addr_in = 32'h0;
   logic          flush_in = 1'b0;
   logic [31:0]   if_data_out;
   logic          if_done_out, if_blk_out;
   logic          mem_req_in = 1'b0;
   logic          mem_we_in = 1'b0;
   logic [2:0]    mem_len_in = 3'd0;
   logic [31:0]   mem_addr_in = 32'h0;
   logic [31:0]   mem_wdata_in = 32'h0;
   logic [31:0]   mem_rdata_out;
   logic          mem_done_out, mem_blk_out;
   logic [AW-1:0] ram_addr_out;
   logic          ram_wr_out;
   logic [7:0]    ram_dout;
   logic [7:0]    ram_din;

   int checks = 0;
   int errors = 0;
   int wrCount = 0;

   logic [7:0] refMem [MEMSZ];
   logic [7:0] ramArr [MEMSZ];

   mem_ctrl #(.ADDR_W(AW)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .if_req_in     (if_req_in),
      .if_addr_in    (if_addr_in),
      .flush_in      (flush_in),
      .if_data_out   (if_data_out),
      .if_done_out   (if_done_out),
      .if_blk_out    (if_blk_out),
      .mem_req_in    (mem_req_in),
      .mem_we_in     (mem_we_in),
      .mem_len_in    (mem_len_in),
      .mem_addr_in   (mem_addr_in),
      .mem_wdata_in  (mem_wdata_in),
      .mem_rdata_out (mem_rdata_out),
      .mem_done_out  (mem_done_out),
      .mem_blk_out   (mem_blk_out),
      .ram_addr_out  (ram_addr_out),
      .ram_wr_out    (ram_wr_out),
      .ram_dout      (ram_dout),
      .ram_din       (ram_din)
   );

   // Free-running clock.
   always #5 clk_in = ~clk_in;

   // Deterministic power-up RAM image with the known instruction at 0x1000.
   function automatic logic [7:0] initByte(input int a);
      logic [31:0] h;
      case (a)
         32'h1000: return 8'h13;
         32'h1001: return 8'h05;
         32'h1002: return 8'h00;
         32'h1003: return 8'h00;
         default: begin
            h = a * 32'd2654435761;
            return h[23:16];
         end
      endcase
   endfunction

   // Synchronous byte RAM: write on strobe, read data one cycle after address.
   initial begin
      for (int a = 0; a < MEMSZ; a++) ramArr[a] = initByte(a);
      ram_din = 8'h00;
      forever begin
         @(posedge clk_in);
         if (ram_wr_out) ramArr[ram_addr_out] = ram_dout;
         ram_din <= ramArr[ram_addr_out];
      end
   end

   // Count RAM write strobes.
   always @(posedge clk_in) begin
      if (ram_wr_out) wrCount = wrCount + 1;
   end

   function automatic int nBytes(input logic [2:0] len);
      case (len)
         3'd1:    return 1;
         3'd2:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic [31:0] expLoad(input logic [31:0] addr, input int n);
      logic [31:0] w;
      logic [31:0] a;
      w = 32'h0;
      for (int i = 0; i < n; i++) begin
         a = addr + i;
         w = w | (32'(refMem[a[AW-1:0]]) << (8 * i));
      end
      return w;
   endfunction

   task automatic refStore(input logic [31:0] addr, input logic [31:0] wdata, input int n);
      logic [31:0] a;
      for (int i = 0; i < n; i++) begin
         a = addr + i;
         refMem[a[AW-1:0]] = wdata[8*i +: 8];
      end
   endtask

   // Issue one request from the IDLE cycle, wait (bounded) for its done pulse,
   // release the request and return once the controller is idle again.
   task automatic applyStimulus(input bit isMem, input bit we, input logic [2:0] len,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] data, output int cycles,
                                output bit timedOut, output int wrDelta);
      int wr0;
      wr0 = wrCount;
      cycles = 0;
      timedOut = 1'b1;
      data = 32'h0;
      if (isMem) begin
         mem_req_in = 1'b1; mem_we_in = we; mem_len_in = len;
         mem_addr_in = addr; mem_wdata_in = wdata;
      end else begin
         if_req_in = 1'b1; if_addr_in = addr;
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (isMem ? mem_done_out : if_done_out) begin
            cycles = c;
            timedOut = 1'b0;
            data = isMem ? mem_rdata_out : if_data_out;
            break;
         end
      end
      mem_req_in = 1'b0;
      if_req_in = 1'b0;
      @(negedge clk_in);
      wrDelta = wrCount - wr0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk_in);
      checks++;
      if ({if_done_out, mem_done_out} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL reset_done got=%b exp=00", {if_done_out, mem_done_out});
      end
      checks++;
      if (if_data_out !== 32'h0 || mem_rdata_out !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_data got=%h/%h exp=0/0", if_data_out, mem_rdata_out);
      end
      checks++;
      if ({ram_wr_out, ram_addr_out, ram_dout} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_ram got wr=%b addr=%h dout=%h exp=0", ram_wr_out, ram_addr_out, ram_dout);
      end
      rst_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_fetch();
      logic [31:0] d; int cyc, wrd; bit to;
      applyStimulus(1'b0, 1'b0, 3'd4, 32'h1000, 32'h0, d, cyc, to, wrd);
      checks++;
      if (to || cyc != 6) begin
         errors++;
         $display("[TB] FAIL fetch_latency got=%0d exp=6 timeout=%0d", cyc, to);
      end
      checks++;
      if (d !== 32'h0000_0513) begin
         errors++;
         $display("[TB] FAIL fetch_data got=%h exp=00000513", d);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] d; int cyc, wrd; bit to;
      int seen, busy;
      if_req_in = 1'b1; if_addr_in = 32'h1000;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
      #1;
      checks++;
      if (if_data_out !== 32'h0 || if_done_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_outputs got data=%h done=%b exp=0", if_data_out, if_done_out);
      end
      checks++;
      if (ram_addr_out !== '0) begin
         errors++;
         $display("[TB] FAIL rstmid_addr got=%h exp=0", ram_addr_out);
      end
      if_req_in = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b0;
      seen = 0; busy = 0;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (if_done_out) seen++;
         if (ram_addr_out !== '0) busy++;
      end
      checks++;
      if (seen != 0 || busy != 0) begin
         errors++;
         $display("[TB] FAIL rstmid_idle got done=%0d busy=%0d exp=0/0", seen, busy);
      end
      applyStimulus(1'b0, 1'b0, 3'd4, 32'h1000, 32'h0, d, cyc, to, wrd);
      checks++;
      if (to || cyc != 6 || d !== 32'h0000_0513) begin
         errors++;
         $display("[TB] FAIL rstmid_refetch got=%h/%0d exp=00000513/6", d, cyc);
      end
   endtask

   task automatic test_store_load();
      logic [31:0] d, e; int cyc, wrd; bit to;
      applyStimulus(1'b1, 1'b1, 3'd2, 32'h20, 32'hA1B2_C3D4, d, cyc, to, wrd);
      refStore(32'h20, 32'hA1B2_C3D4, 2);
      checks++;
      if (to || cyc != 3) begin
         errors++;
         $display("[TB] FAIL store_latency got=%0d exp=3", cyc);
      end
      checks++;
      if (wrd != 2) begin
         errors++;
         $display("[TB] FAIL store_wrcount got=%0d exp=2", wrd);
      end
      applyStimulus(1'b1, 1'b0, 3'd1, 32'h20, 32'h0, d, cyc, to, wrd);
      checks++;
      if (to || cyc != 3 || d !== 32'h0000_00D4) begin
         errors++;
         $display("[TB] FAIL load_byte20 got=%h/%0d exp=000000d4/3", d, cyc);
      end
      applyStimulus(1'b1, 1'b0, 3'd1, 32'h21, 32'h0, d, cyc, to, wrd);
      checks++;
      if (d !== 32'h0000_00C3) begin
         errors++;
         $display("[TB] FAIL load_byte21 got=%h exp=000000c3", d);
      end
      e = {24'h0, initByte(32'h22)};
      applyStimulus(1'b1, 1'b0, 3'd1, 32'h22, 32'h0, d, cyc, to, wrd);
      checks++;
      if (d !== e) begin
         errors++;
         $display("[TB] FAIL load_byte22_untouched got=%h exp=%h", d, e);
      end
      e = expLoad(32'h1FFFF, 4);
      applyStimulus(1'b1, 1'b0, 3'd4, 32'h1FFFF, 32'h0, d, cyc, to, wrd);
      checks++;
      if (to || cyc != 6 || d !== e) begin
         errors++;
         $display("[TB] FAIL load_wrap got=%h/%0d exp=%h/6", d, cyc, e);
      end
   endtask

   task automatic test_arbitration();
      logic [31:0] expMem, expIf;
      int memCyc, ifCyc; bit ifEarly;
      expMem = expLoad(32'h1000, 4);
      expIf = expLoad(32'h20, 4);
      memCyc = 0; ifCyc = 0; ifEarly = 1'b0;
      mem_req_in = 1'b1; mem_we_in = 1'b0; mem_len_in = 3'd4; mem_addr_in = 32'h1000;
      if_req_in = 1'b1; if_addr_in = 32'h20;
      #1;
      checks++;
      if (if_blk_out !== 1'b1 || mem_blk_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_blk got=%b%b exp=11", if_blk_out, mem_blk_out);
      end
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (if_done_out) ifEarly = 1'b1;
         if (mem_done_out) begin memCyc = c; break; end
      end
      checks++;
      if (memCyc != 6 || mem_rdata_out !== expMem) begin
         errors++;
         $display("[TB] FAIL arb_mem got=%h/%0d exp=%h/6", mem_rdata_out, memCyc, expMem);
      end
      checks++;
      if (ifEarly) begin
         errors++;
         $display("[TB] FAIL arb_if_early got=1 exp=0");
      end
      checks++;
      if (if_blk_out !== 1'b1 || mem_blk_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arb_blk_done got=%b%b exp=10", if_blk_out, mem_blk_out);
      end
      mem_req_in = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (if_done_out) begin ifCyc = c; break; end
      end
      checks++;
      if (ifCyc != 7 || if_data_out !== expIf) begin
         errors++;
         $display("[TB] FAIL arb_if got=%h/%0d exp=%h/7", if_data_out, ifCyc, expIf);
      end
      if_req_in = 1'b0;
      @(negedge clk_in);
   endtask

   task automatic test_flush();
      logic [31:0] d, e; int cyc, wrd; bit to;
      int seen;
      if_req_in = 1'b1; if_addr_in = 32'h1000;
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if (ram_addr_out !== 17'h01002) begin
         errors++;
         $display("[TB] FAIL flush_cnt2_addr got=%h exp=01002", ram_addr_out);
      end
      flush_in = 1'b1; if_req_in = 1'b0;
      @(posedge clk_in);
      @(negedge clk_in);
      checks++;
      if (ram_addr_out !== '0 || ram_wr_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_idle got addr=%h wr=%b exp=0/0", ram_addr_out, ram_wr_out);
      end
      seen = if_done_out ? 1 : 0;
      flush_in = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk_in);
         @(negedge clk_in);
         if (if_done_out) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL flush_no_done got=%0d exp=0", seen);
      end
      e = expLoad(32'h2000, 4);
      applyStimulus(1'b0, 1'b0, 3'd4, 32'h2000, 32'h0, d, cyc, to, wrd);
      checks++;
      if (to || cyc != 6 || d !== e) begin
         errors++;
         $display("[TB] FAIL flush_refetch got=%h/%0d exp=%h/6", d, cyc, e);
      end
      if_req_in = 1'b1; if_addr_in = 32'h1000;
      repeat (6) @(posedge clk_in);
      #1 flush_in = 1'b1;
      #1;
      checks++;
      if (if_done_out !== 1'b0) begin
         errors++;
         $display("[TB] FAIL flush_done_suppress got=%b exp=0", if_done_out);
      end
      checks++;
      if (if_blk_out !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_done_blk got=%b exp=1", if_blk_out);
      end
      @(negedge clk_in);
      if_req_in = 1'b0;
      @(posedge clk_in);
      #1 flush_in = 1'b0;
      @(negedge clk_in);
      flush_in = 1'b1;
      applyStimulus(1'b1, 1'b0, 3'd4, 32'h1000, 32'h0, d, cyc, to, wrd);
      flush_in = 1'b0;
      checks++;
      if (to || cyc != 6 || d !== 32'h0000_0513) begin
         errors++;
         $display("[TB] FAIL flush_mem_immune got=%h/%0d exp=00000513/6", d, cyc);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, e, addr, wdata; int cyc, wrd, n; bit to, we;
      logic [2:0] len;
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 1) == 0)
            addr = 32'h300 + $urandom_range(0, 63);
         else
            addr = 32'h1FFF8 + $urandom_range(0, 7);
         if ($urandom_range(0, 1) == 1) addr = addr | ($urandom & 32'hFFFE_0000);
         if ($urandom_range(0, 4) == 0) begin
            e = expLoad(addr, 4);
            applyStimulus(1'b0, 1'b0, 3'd4, addr, 32'h0, d, cyc, to, wrd);
            checks++;
            if (to || cyc != 6 || d !== e || wrd != 0) begin
               errors++;
               $display("[TB] FAIL rand_fetch it=%0d addr=%h got=%h/%0d/%0d exp=%h/6/0", it, addr, d, cyc, wrd, e);
            end
         end else begin
            we = 1'($urandom_range(0, 1));
            len = 3'($urandom_range(0, 7));
            wdata = $urandom;
            n = nBytes(len);
            if (we) begin
               applyStimulus(1'b1, 1'b1, len, addr, wdata, d, cyc, to, wrd);
               refStore(addr, wdata, n);
               checks++;
               if (to || cyc != n + 1 || wrd != n) begin
                  errors++;
                  $display("[TB] FAIL rand_store it=%0d addr=%h len=%0d got cyc=%0d wr=%0d exp=%0d/%0d", it, addr, len, cyc, wrd, n + 1, n);
               end
            end else begin
               e = expLoad(addr, n);
               applyStimulus(1'b1, 1'b0, len, addr, 32'h0, d, cyc, to, wrd);
               checks++;
               if (to || cyc != n + 2 || d !== e || wrd != 0) begin
                  errors++;
                  $display("[TB] FAIL rand_load it=%0d addr=%h len=%0d got=%h/%0d exp=%h/%0d", it, addr, len, d, cyc, e, n + 2);
               end
            end
         end
      end
   endtask

   // Scenario sequence; every failing comparison increments errors before printing its FAIL line.
   initial begin
      for (int a = 0; a < MEMSZ; a++) refMem[a] = initByte(a);
      $display("[TB] starting mem_ctrl scenarios");
      test_reset();
      test_fetch();
      test_reset_mid();
      test_store_load();
      test_arbitration();
      test_flush();
      test_random();
      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
